// File: rtl/fifo_unpack_reader.sv
// Pops wide show-ahead FIFO entries and streams them as narrow valid/ready beats, LSB slice first.
// Define FIFO_UNPACK_BEAT_COUNT_EN to add a 32-bit accepted-beat counter output.
module fifo_unpack_reader #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_en,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_value,
    output logic                 fifo_dequeue_en,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_first,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 idle
`ifdef FIFO_UNPACK_BEAT_COUNT_EN
    ,
    output logic [31:0]          beat_count
`endif
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW    = $clog2(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    localparam logic IDLE_S   = 1'b0;
    localparam logic ACTIVE_S = 1'b1;

    logic                               state_q;
    logic [BW-1:0]                      beat_q;
    logic [RATIO-1:0][OUT_WIDTH-1:0]    word_q;
    logic                               accept;
    logic                               load;

    assign out_valid = state_q == ACTIVE_S;
    assign idle      = state_q == IDLE_S;
    assign out_data  = word_q[beat_q];
    assign out_first = out_valid && beat_q == '0;
    assign out_last  = out_valid && beat_q == LAST_BEAT;
    assign accept    = out_valid && out_ready;

    // A new word is taken either from idle or in the same cycle the last beat leaves.
    assign load = !reset && !flush_en && !fifo_empty
                  && (idle || (accept && out_last));
    assign fifo_dequeue_en = load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_S;
            beat_q  <= '0;
        end else if (flush_en) begin
            state_q <= IDLE_S;
            beat_q  <= '0;
        end else if (load) begin
            state_q <= ACTIVE_S;
            beat_q  <= '0;
        end else if (accept) begin
            if (out_last) begin
                state_q <= IDLE_S;
                beat_q  <= '0;
            end else begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            word_q <= fifo_value;
        end
    end

`ifdef FIFO_UNPACK_BEAT_COUNT_EN
    // Beats taken during a flush still count: the consumer did receive them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (accept) begin
            beat_count <= beat_count + 32'd1;
        end
    end
`endif

    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (reset) !(fifo_dequeue_en && fifo_empty)
    );

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Bench for fifo_unpack_reader: directed vector table, async reset checks,
// and a randomized run against a queue-based beat-stream reference model.
module tb_fifo_unpack_reader;

    localparam int IW    = 64;
    localparam int OW    = 16;
    localparam int RATIO = IW / OW;

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] W2 = 64'h8888_7777_6666_5555;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_en;
    logic          fifo_empty;
    logic [IW-1:0] fifo_value;
    logic          fifo_dequeue_en;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic          out_ready;
    logic          idle;
`ifdef FIFO_UNPACK_BEAT_COUNT_EN
    logic [31:0]   beat_count;
`endif

    int tests = 0;
    int fails = 0;

    fifo_unpack_reader #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_en        (flush_en),
        .fifo_empty      (fifo_empty),
        .fifo_value      (fifo_value),
        .fifo_dequeue_en (fifo_dequeue_en),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_first       (out_first),
        .out_last        (out_last),
        .out_ready       (out_ready),
        .idle            (idle)
`ifdef FIFO_UNPACK_BEAT_COUNT_EN
        ,
        .beat_count      (beat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          has;
        logic [63:0]   val;
        logic          rdy;
        logic          ev;
        logic [15:0]   ed;
        logic          ef;
        logic          el;
        logic          edq;
        logic          eid;
    } vec_t;

    typedef struct {
        logic [OW-1:0] data;
        logic          first;
        logic          last;
    } beat_t;

    vec_t          vecs[$];
    logic [IW-1:0] fifo_q[$];
    beat_t         exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic fl, input logic has,
                                input logic [63:0] val, input logic rdy,
                                input logic ev, input logic [15:0] ed,
                                input logic ef, input logic el,
                                input logic edq, input logic eid);
        vec_t v;
        v.fl = fl; v.has = has; v.val = val; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ef = ef; v.el = el;
        v.edq = edq; v.eid = eid;
        vecs.push_back(v);
    endfunction

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic do_reset();
        reset      = 1'b1;
        flush_en   = 1'b0;
        fifo_empty = 1'b0;
        fifo_value = W1;
        out_ready  = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_deq", 64'(fifo_dequeue_en), 64'd0);
        chk("rst_first_last", {62'd0, out_first, out_last}, 64'd0);
        @(negedge clk);
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_q.delete();
        exp_q.delete();
    endtask

    // One cycle against the reference model: the stream of expected beats is
    // every popped word's slices in order, with a flush discarding the rest.
    task automatic model_cycle(input logic rdy, input logic fl);
        logic          mv;
        logic          edq;
        logic [IW-1:0] w;
        beat_t         b;
        flush_en   = fl;
        out_ready  = rdy;
        fifo_empty = fifo_q.size() == 0;
        fifo_value = fifo_q.size() != 0 ? fifo_q[0] : {$urandom, $urandom};
        #3;
        mv  = exp_q.size() != 0;
        edq = !fl && fifo_q.size() != 0
              && (!mv || (rdy && exp_q.size() == 1));
        chk("m_valid", 64'(out_valid), 64'(mv));
        chk("m_idle", 64'(idle), 64'(!mv));
        chk("m_deq", 64'(fifo_dequeue_en), 64'(edq));
        if (mv) begin
            chk("m_data", 64'(out_data), 64'(exp_q[0].data));
            chk("m_first", 64'(out_first), 64'(exp_q[0].first));
            chk("m_last", 64'(out_last), 64'(exp_q[0].last));
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (mv && rdy) void'(exp_q.pop_front());
            if (edq) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < RATIO; i++) begin
                    b.data  = w[i*OW +: OW];
                    b.first = i == 0;
                    b.last  = i == RATIO - 1;
                    exp_q.push_back(b);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        flush_en   = 1'b0;
        fifo_empty = 1'b1;
        fifo_value = '0;
        out_ready  = 1'b0;

        // single word
        add(0, 1, W1, 1, 0, 16'h0,    0, 0, 1, 1);
        add(0, 0, 0,  1, 1, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h2222, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h3333, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h4444, 0, 1, 0, 0);
        add(0, 0, 0,  1, 0, 16'h0,    0, 0, 0, 1);
        // back-to-back
        add(0, 1, W1, 1, 0, 16'h0,    0, 0, 1, 1);
        add(0, 1, W2, 1, 1, 16'h1111, 1, 0, 0, 0);
        add(0, 1, W2, 1, 1, 16'h2222, 0, 0, 0, 0);
        add(0, 1, W2, 1, 1, 16'h3333, 0, 0, 0, 0);
        add(0, 1, W2, 1, 1, 16'h4444, 0, 1, 1, 0);
        add(0, 0, 0,  1, 1, 16'h5555, 1, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h6666, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h7777, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h8888, 0, 1, 0, 0);
        add(0, 0, 0,  1, 0, 16'h0,    0, 0, 0, 1);
        // backpressure on beat 1
        add(0, 1, W1, 1, 0, 16'h0,    0, 0, 1, 1);
        add(0, 0, 0,  1, 1, 16'h1111, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, W2, 0, 1, 16'h2222, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h2222, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h3333, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h4444, 0, 1, 0, 0);
        add(0, 0, 0,  1, 0, 16'h0,    0, 0, 0, 1);
        // flush mid-word
        add(0, 1, W1, 1, 0, 16'h0,    0, 0, 1, 1);
        add(0, 0, 0,  1, 1, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h2222, 0, 0, 0, 0);
        add(1, 1, W2, 1, 1, 16'h3333, 0, 0, 0, 0);
        add(0, 1, W2, 1, 0, 16'h0,    0, 0, 1, 1);
        add(0, 0, 0,  1, 1, 16'h5555, 1, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h6666, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h7777, 0, 0, 0, 0);
        add(0, 0, 0,  1, 1, 16'h8888, 0, 1, 0, 0);
        add(0, 0, 0,  1, 0, 16'h0,    0, 0, 0, 1);
        // empty FIFO
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, i[0], 0, 16'h0, 0, 0, 0, 1);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            flush_en   = vecs[i].fl;
            fifo_empty = !vecs[i].has;
            fifo_value = vecs[i].val;
            out_ready  = vecs[i].rdy;
            #3;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("v%0d_deq", i), 64'(fifo_dequeue_en), 64'(vecs[i].edq));
            chk($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].eid));
            chk($sformatf("v%0d_fl", i), {62'd0, out_first, out_last},
                {62'd0, vecs[i].ef, vecs[i].el});
            if (vecs[i].ev)
                chk($sformatf("v%0d_data", i), 64'(out_data), 64'(vecs[i].ed));
            @(negedge clk);
        end

        // async reset mid-word
        flush_en   = 1'b0;
        fifo_empty = 1'b0;
        fifo_value = W1;
        out_ready  = 1'b0;
        @(negedge clk);
        fifo_empty = 1'b1;
        #2;
        chk("mid_valid_before", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_valid_async", 64'(out_valid), 64'd0);
        chk("mid_idle_async", 64'(idle), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("mid_valid_after", 64'(out_valid), 64'd0);
        @(negedge clk);

`ifdef FIFO_UNPACK_BEAT_COUNT_EN
        do_reset();
        chk("cnt_reset", 64'(beat_count), 64'd0);
        for (int i = 0; i < 3; i++)
            fifo_q.push_back({$urandom, $urandom});
        for (int i = 0; i < 15; i++)
            model_cycle(1'b1, 1'b0);
        chk("cnt_12", 64'(beat_count), 64'd12);
        model_cycle(1'b1, 1'b1);
        chk("cnt_flush", 64'(beat_count), 64'd12);
        reset = 1'b1;
        #1;
        chk("cnt_async_rst", 64'(beat_count), 64'd0);
        @(negedge clk);
`endif

        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0)
                fifo_q.push_back({$urandom, $urandom});
            model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_unpack_reader.md
Name: fifo_unpack_reader

Overview:
- Read-side companion to the synchronous show-ahead FIFO.
- Pops IN_WIDTH-bit entries from the FIFO's read port (empty, dequeue_en, value_o) and serializes each into RATIO = IN_WIDTH/OUT_WIDTH narrower beats, least-significant slice first.
- Output is a valid/ready stream.
- Used wherever a wide queued word must be fed to a narrow consumer (e.g. a bus or debug port) without bubbles between words.

Parameters:
IN_WIDTH, 64, width of a FIFO entry; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 16, width of one output beat.
(localparam) RATIO = IN_WIDTH/OUT_WIDTH; must be a power of two and at least 2. Beat index width is $clog2(RATIO).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush_en  in  1  synchronous flush; discards any partially sent word
fifo_empty  in  1  FIFO empty flag
fifo_value  in  IN_WIDTH  FIFO head entry (show-ahead; valid while !fifo_empty)
fifo_dequeue_en  out  1  pop FIFO head this cycle (combinational)
out_valid  out  1  beat valid
out_data  out  OUT_WIDTH  current beat
out_first  out  1  beat index == 0
out_last  out  1  beat index == RATIO-1
out_ready  in  1  consumer accepts beat
idle  out  1  no word held (state IDLE)

Behaviour:
- State: IDLE or ACTIVE (registered). Holding register word_q [IN_WIDTH], beat index beat_q.
- Reset (async): state IDLE, beat_q 0, out_valid 0, idle 1, fifo_dequeue_en 0. word_q is don't-care.
- out_valid = (state == ACTIVE). out_data = word_q[beat_q*OUT_WIDTH +: OUT_WIDTH].
- out_first = out_valid && beat_q == 0. out_last = out_valid && beat_q == RATIO-1.
- Load condition: !flush_en && !fifo_empty && (state == IDLE || (out_valid && out_ready && out_last)).
  - fifo_dequeue_en = load condition; it is purely combinational.
  - On load: word_q <= fifo_value, beat_q <= 0, state <= ACTIVE.
- Beat accept (out_valid && out_ready):
  - If not last beat: beat_q <= beat_q + 1.
  - If last beat and no load: state <= IDLE, beat_q <= 0.
- Latency:
  - FIFO going non-empty in cycle N (reader IDLE) -> dequeue in N, out_valid in N+1.
  - Last-beat accept with FIFO non-empty -> next word's beat 0 presented the following cycle, with no bubble.
- Stability: while out_valid && !out_ready, out_data/out_first/out_last hold constant.
- fifo_dequeue_en is never asserted when fifo_empty = 1. The simulation assertion checks this.
- flush_en (precedence over everything):
  - Next cycle: state IDLE, beat_q 0, out_valid 0.
  - fifo_dequeue_en forced 0 in the flush cycle.
  - A beat accepted in the flush cycle is still considered consumed by the consumer but has no further effect.
- Reset mid-word: word discarded, outputs as reset values immediately (asynchronous).
- beat_q wraps only through the last-beat path; it never increments past RATIO-1.

Optional Feature:
- Macro: FIFO_UNPACK_BEAT_COUNT_EN.
- Defined:
  - Adds output port beat_count [31:0], counting accepted beats (out_valid && out_ready).
  - Cleared by reset only, not by flush.
  - Wraps modulo 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single word, defaults: FIFO holds 64'h4444_3333_2222_1111, out_ready=1 -> dequeue 1 cycle; beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 on 4 consecutive cycles; out_first on beat 0, out_last on beat 3; idle returns 1.
- Back-to-back: two words queued, out_ready=1 -> 8 consecutive valid beats with no gap; second dequeue coincides with first word's last-beat accept.
- Backpressure: out_ready=0 for 5 cycles on beat 1 -> out_data holds 16'h2222, beat_q unchanged, no dequeue; resumes correctly when out_ready=1.
- Flush mid-word: flush_en after beat 1 accepted, FIFO non-empty -> no dequeue in flush cycle, out_valid 0 next cycle, remaining beats never appear; next word starts at beat 0 with out_first=1.
- Empty FIFO: fifo_empty=1 throughout -> fifo_dequeue_en never 1, out_valid stays 0, idle 1; async reset asserted mid-word -> out_valid drops immediately.
- With FIFO_UNPACK_BEAT_COUNT_EN: 3 words fully drained, then flush -> beat_count = 12, unchanged by flush, 0 after reset.
